// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/execute sequencer for register-register ALU instructions.
// Optional build macro MEM_TIMEOUT_EN adds a bounded instruction-fetch wait in T1.
module alu_instr_sequencer #(
    parameter int OPCODE_W       = 5,
    parameter int REG_IDX_W      = 4,
    parameter int ALU_OP_MAX     = 11,
    parameter int TIMEOUT_CYCLES = 15,
    localparam int NUM_REGS      = 2 ** REG_IDX_W
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [31:0]         ir_in,
    output logic                PCout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                MARin,
    output logic                ZLowIn,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                IncPC,
    output logic                Read,
    output logic [NUM_REGS-1:0] reg_out_sel,
    output logic [NUM_REGS-1:0] reg_in_sel,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic                mem_err
);

    localparam int LOW_W = 32 - OPCODE_W - 3 * REG_IDX_W;
    localparam logic [OPCODE_W-1:0] OP_MAX = OPCODE_W'(ALU_OP_MAX);

    typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_TRAP} state_t;

    state_t state, state_next;
    logic   t1_waited;  // set after the first T1 cycle so PC update strobes fire once

    logic [OPCODE_W-1:0]  opcode;
    logic [REG_IDX_W-1:0] ra, rb, rc;
    logic                 legal;
    logic                 unused_ir;

    assign opcode    = ir_in[31 -: OPCODE_W];
    assign ra        = ir_in[31 - OPCODE_W -: REG_IDX_W];
    assign rb        = ir_in[31 - OPCODE_W - REG_IDX_W -: REG_IDX_W];
    assign rc        = ir_in[31 - OPCODE_W - 2 * REG_IDX_W -: REG_IDX_W];
    assign legal     = (opcode <= OP_MAX);
    assign unused_ir = ^ir_in[LOW_W-1:0];

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) wait_cnt <= '0;
        else       wait_cnt <= (state == S_T1 && state_next == S_T1) ? wait_cnt + 1'b1 : '0;
    end
`else
    logic timed_out;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            t1_waited <= 1'b0;
            alu_op    <= '0;
        end else begin
            state     <= state_next;
            t1_waited <= (state == S_T1) && (state_next == S_T1);
            // latch on entry to T4 so the ALU result stays stable afterwards
            if (state == S_T3 && legal) alu_op <= opcode;
        end
    end

    always_comb begin
        state_next  = state;
        PCout       = 1'b0;
        Zlowout     = 1'b0;
        MDRout      = 1'b0;
        MARin       = 1'b0;
        ZLowIn      = 1'b0;
        PCin        = 1'b0;
        MDRin       = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        IncPC       = 1'b0;
        Read        = 1'b0;
        reg_out_sel = '0;
        reg_in_sel  = '0;
        done        = 1'b0;
        illegal     = 1'b0;
        mem_err     = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_T0;
            S_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                ZLowIn     = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                if (timed_out) begin
                    mem_err    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    Read    = 1'b1;
                    MDRin   = 1'b1;
                    Zlowout = !t1_waited;
                    PCin    = !t1_waited;
                    if (mem_ready) state_next = S_T2;
                end
            end
            S_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (legal) begin
                    reg_out_sel = NUM_REGS'(1) << rb;
                    Yin         = 1'b1;
                    state_next  = S_T4;
                end else begin
                    state_next  = S_TRAP;
                end
            end
            S_T4: begin
                reg_out_sel = NUM_REGS'(1) << rc;
                ZLowIn      = 1'b1;
                state_next  = S_T5;
            end
            S_T5: begin
                Zlowout    = 1'b1;
                reg_in_sel = NUM_REGS'(1) << ra;
                done       = 1'b1;
                state_next = run ? S_T0 : S_IDLE;
            end
            S_TRAP: begin
                illegal    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed-vector bench for alu_instr_sequencer; each cycle's outputs are compared
// against hand-derived strobe/select/flag vectors.
module tb_alu_instr_sequencer;

    logic        Clock = 1'b0;
    logic        Reset, start, run, mem_ready;
    logic [31:0] ir_in;
    logic        PCout, Zlowout, MDRout, MARin, ZLowIn, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic [15:0] reg_out_sel, reg_in_sel;
    logic [4:0]  alu_op;
    logic        busy, done, illegal, mem_err;

    int nchk  = 0;
    int nfail = 0;

    // strobe order: PCout Zlowout MDRout MARin ZLowIn PCin MDRin IRin Yin IncPC Read
    localparam logic [10:0] S_T0  = 11'h4C2;
    localparam logic [10:0] S_T1F = 11'h231;
    localparam logic [10:0] S_T1W = 11'h011;
    localparam logic [10:0] S_T2  = 11'h108;
    localparam logic [10:0] S_T3  = 11'h004;
    localparam logic [10:0] S_T4  = 11'h040;
    localparam logic [10:0] S_T5  = 11'h200;
    // flags order: busy done illegal mem_err
    localparam logic [3:0]  F_B   = 4'b1000;
    localparam logic [3:0]  F_BD  = 4'b1100;
    localparam logic [3:0]  F_BI  = 4'b1010;
    localparam logic [3:0]  F_BE  = 4'b1001;

    alu_instr_sequencer dut (
        .Clock(Clock), .Reset(Reset), .start(start), .run(run), .mem_ready(mem_ready),
        .ir_in(ir_in), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
        .ZLowIn(ZLowIn), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC),
        .Read(Read), .reg_out_sel(reg_out_sel), .reg_in_sel(reg_in_sel), .alu_op(alu_op),
        .busy(busy), .done(done), .illegal(illegal), .mem_err(mem_err)
    );

    always #5 Clock = ~Clock;

    function automatic logic [46:0] snap();
        return {PCout, Zlowout, MDRout, MARin, ZLowIn, PCin, MDRin, IRin, Yin, IncPC, Read,
                reg_out_sel, reg_in_sel, busy, done, illegal, mem_err};
    endfunction

    function automatic logic [46:0] ev(logic [10:0] s, logic [15:0] o, logic [15:0] i, logic [3:0] f);
        return {s, o, i, f};
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 1'b0; run = 1'b0; mem_ready = 1'b1; ir_in = 32'h0;
        #2;
        nchk++;
        if (snap() !== 47'h0 || alu_op !== 5'd0) begin
            nfail++;
            $display("FAIL reset_async: got %h op %0d expected 0", snap(), alu_op);
        end
        step();
        nchk++;
        if (snap() !== 47'h0) begin
            nfail++;
            $display("FAIL reset_edge: got %h expected 0", snap());
        end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_or();
        logic [46:0] exp [0:6];
        exp[0] = ev(S_T0, 16'h0, 16'h0, F_B);
        exp[1] = ev(S_T1F, 16'h0, 16'h0, F_B);
        exp[2] = ev(S_T2, 16'h0, 16'h0, F_B);
        exp[3] = ev(S_T3, 16'h0004, 16'h0, F_B);
        exp[4] = ev(S_T4, 16'h0008, 16'h0, F_B);
        exp[5] = ev(S_T5, 16'h0, 16'h0002, F_BD);
        exp[6] = 47'h0;
        ir_in = 32'h18918000; mem_ready = 1'b1; run = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            nchk++;
            if (snap() !== exp[i]) begin
                nfail++;
                $display("FAIL or_seq c%0d: got %h expected %h", i, snap(), exp[i]);
            end
            if (i == 4) begin
                nchk++;
                if (alu_op !== 5'd3) begin
                    nfail++;
                    $display("FAIL or_aluop: got %0d expected 3", alu_op);
                end
            end
            if (i < 6) step();
        end
        nchk++;
        if (alu_op !== 5'd3) begin
            nfail++;
            $display("FAIL or_aluop_hold: got %0d expected 3", alu_op);
        end
    endtask

    task automatic test_wait_states();
        logic [46:0] exp [0:9];
        exp[0] = ev(S_T0, 16'h0, 16'h0, F_B);
        exp[1] = ev(S_T1F, 16'h0, 16'h0, F_B);
        exp[2] = ev(S_T1W, 16'h0, 16'h0, F_B);
        exp[3] = ev(S_T1W, 16'h0, 16'h0, F_B);
        exp[4] = ev(S_T1W, 16'h0, 16'h0, F_B);
        exp[5] = ev(S_T2, 16'h0, 16'h0, F_B);
        exp[6] = ev(S_T3, 16'h0004, 16'h0, F_B);
        exp[7] = ev(S_T4, 16'h0008, 16'h0, F_B);
        exp[8] = ev(S_T5, 16'h0, 16'h0002, F_BD);
        exp[9] = 47'h0;
        ir_in = 32'h18918000; mem_ready = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            nchk++;
            if (snap() !== exp[i]) begin
                nfail++;
                $display("FAIL wait_seq c%0d: got %h expected %h", i, snap(), exp[i]);
            end
            if (i == 4) mem_ready = 1'b1;
            if (i < 9) step();
        end
    endtask

    task automatic test_illegal();
        logic [31:0] irs [0:1];
        logic [46:0] exp [0:5];
        irs[0] = 32'hF8000000;   // opcode 31
        irs[1] = 32'h60000000;   // opcode 12, first illegal value
        exp[0] = ev(S_T0, 16'h0, 16'h0, F_B);
        exp[1] = ev(S_T1F, 16'h0, 16'h0, F_B);
        exp[2] = ev(S_T2, 16'h0, 16'h0, F_B);
        exp[3] = ev(11'h0, 16'h0, 16'h0, F_B);
        exp[4] = ev(11'h0, 16'h0, 16'h0, F_BI);
        exp[5] = 47'h0;
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ir_in = irs[k];
            start = 1'b1; step(); start = 1'b0;
            for (int i = 0; i < 6; i++) begin
                nchk++;
                if (snap() !== exp[i]) begin
                    nfail++;
                    $display("FAIL illegal_seq%0d c%0d: got %h expected %h", k, i, snap(), exp[i]);
                end
                if (i < 5) step();
            end
        end
        nchk++;
        if (alu_op !== 5'd3) begin
            nfail++;
            $display("FAIL illegal_aluop_hold: got %0d expected 3", alu_op);
        end
    endtask

    task automatic test_back_to_back();
        logic [46:0] exp [0:12];
        exp[0]  = ev(S_T0, 16'h0, 16'h0, F_B);
        exp[1]  = ev(S_T1F, 16'h0, 16'h0, F_B);
        exp[2]  = ev(S_T2, 16'h0, 16'h0, F_B);
        exp[3]  = ev(S_T3, 16'h0010, 16'h0, F_B);
        exp[4]  = ev(S_T4, 16'h0010, 16'h0, F_B);
        exp[5]  = ev(S_T5, 16'h0, 16'h0010, F_BD);
        exp[6]  = ev(S_T0, 16'h0, 16'h0, F_B);
        exp[7]  = ev(S_T1F, 16'h0, 16'h0, F_B);
        exp[8]  = ev(S_T2, 16'h0, 16'h0, F_B);
        exp[9]  = ev(S_T3, 16'h0001, 16'h0, F_B);
        exp[10] = ev(S_T4, 16'h8000, 16'h0, F_B);
        exp[11] = ev(S_T5, 16'h0, 16'h8000, F_BD);
        exp[12] = 47'h0;
        ir_in = 32'h2A220000;    // op 5, ra=rb=rc=4
        mem_ready = 1'b1; run = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 6) ir_in = 32'h5F878000;   // op 11 (max legal), ra=15 rb=0 rc=15
            nchk++;
            if (snap() !== exp[i]) begin
                nfail++;
                $display("FAIL b2b_seq c%0d: got %h expected %h", i, snap(), exp[i]);
            end
            if (i == 4 || i == 10) begin
                nchk++;
                if (alu_op !== ((i == 4) ? 5'd5 : 5'd11)) begin
                    nfail++;
                    $display("FAIL b2b_aluop c%0d: got %0d expected %0d", i, alu_op, (i == 4) ? 5 : 11);
                end
            end
            if (i == 11) run = 1'b0;
            if (i < 12) step();
        end
    endtask

    task automatic test_reset_mid();
        logic idle_bad;
        ir_in = 32'h18918000; mem_ready = 1'b1; run = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
        nchk++;
        if (snap() !== ev(S_T4, 16'h0008, 16'h0, F_B)) begin
            nfail++;
            $display("FAIL rstmid_t4: got %h expected %h", snap(), ev(S_T4, 16'h0008, 16'h0, F_B));
        end
        #2 Reset = 1'b1;
        #1;
        nchk++;
        if (snap() !== 47'h0 || alu_op !== 5'd0) begin
            nfail++;
            $display("FAIL rstmid_async: got %h op %0d expected 0", snap(), alu_op);
        end
        step();
        Reset = 1'b0;
        idle_bad = 1'b0;
        repeat (3) begin
            step();
            if (snap() !== 47'h0) idle_bad = 1'b1;
        end
        nchk++;
        if (idle_bad) begin
            nfail++;
            $display("FAIL rstmid_no_resume: got %h expected 0", snap());
        end
        start = 1'b1; step(); start = 1'b0;
        nchk++;
        if (snap() !== ev(S_T0, 16'h0, 16'h0, F_B)) begin
            nfail++;
            $display("FAIL rstmid_restart: got %h expected %h", snap(), ev(S_T0, 16'h0, 16'h0, F_B));
        end
        repeat (6) step();
        nchk++;
        if (snap() !== 47'h0) begin
            nfail++;
            $display("FAIL rstmid_final_idle: got %h expected 0", snap());
        end
    endtask

    task automatic test_fetch_stall();
`ifdef MEM_TIMEOUT_EN
        logic [46:0] e;
        mem_ready = 1'b0; ir_in = 32'h18918000;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i == 0)       e = ev(S_T0, 16'h0, 16'h0, F_B);
            else if (i == 1)  e = ev(S_T1F, 16'h0, 16'h0, F_B);
            else if (i < 16)  e = ev(S_T1W, 16'h0, 16'h0, F_B);
            else if (i == 16) e = ev(11'h0, 16'h0, 16'h0, F_BE);
            else              e = 47'h0;
            nchk++;
            if (snap() !== e) begin
                nfail++;
                $display("FAIL timeout_seq c%0d: got %h expected %h", i, snap(), e);
            end
            if (i < 17) step();
        end
        mem_ready = 1'b1;
`else
        logic stuck_bad;
        mem_ready = 1'b0; ir_in = 32'h18918000;
        start = 1'b1; step(); start = 1'b0;
        step();
        stuck_bad = 1'b0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (snap() !== ev(S_T1W, 16'h0, 16'h0, F_B)) stuck_bad = 1'b1;
        end
        nchk++;
        if (stuck_bad) begin
            nfail++;
            $display("FAIL stall_hold: got %h expected %h", snap(), ev(S_T1W, 16'h0, 16'h0, F_B));
        end
        Reset = 1'b1; step(); Reset = 1'b0; mem_ready = 1'b1;
        step();
        nchk++;
        if (snap() !== 47'h0) begin
            nfail++;
            $display("FAIL stall_recover: got %h expected 0", snap());
        end
`endif
    endtask

    initial begin
        test_reset();
        test_or();
        test_wait_states();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_fetch_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Hardwired control unit that replaces hand-driven control strobes for register-register ALU instructions.
- Each instruction runs fetch (T0-T2) then execute (T3-T5) and drives the existing datapath strobes.
- Generalises the fixed single-op sequence to a parametrised opcode field and register index width, one-hot register select buses, memory wait states and continuous run mode.
- Sits between instruction memory/MDR handshake and the datapath bus/register file.

Parameters:
OPCODE_W, 5, opcode field width at ir_in[31 -: OPCODE_W]
REG_IDX_W, 4, register index width; NUM_REGS = 2**REG_IDX_W (localparam)
ALU_OP_MAX, 11, highest legal ALU opcode; opcode > ALU_OP_MAX is illegal
TIMEOUT_CYCLES, 15, max T1 wait cycles (used only with MEM_TIMEOUT_EN)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high
start  in  1  begin instruction when idle
run  in  1  sampled in T5: 1 = fetch next instruction immediately
mem_ready  in  1  instruction memory data valid on Mdatain
ir_in  in  32  current IR contents from datapath
PCout, Zlowout, MDRout, MARin, ZLowIn, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each  datapath strobes
reg_out_sel  out  NUM_REGS  one-hot register-to-bus enable
reg_in_sel  out  NUM_REGS  one-hot register load enable
alu_op  out  OPCODE_W  ALU operation code
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse in T5
illegal  out  1  one-cycle pulse on illegal opcode
mem_err  out  1  one-cycle pulse on fetch timeout (0 if feature absent)

Behaviour:
- IR layout: opcode top OPCODE_W bits. Then ra (dest), rb (src1), rc (src2), each REG_IDX_W bits, packed downward. Defaults: op[31:27], ra[26:23], rb[22:19], rc[18:15].
- Moore FSM. All outputs decode from the registered state and registered wait counter only.
- States: IDLE, T0, T1, T2, T3, T4, T5, TRAP.
- Reset (any time, including mid-instruction): state=IDLE; every output 0 asynchronously; counters cleared.
- IDLE: all strobes 0. start=1 at a clock edge -> T0 next cycle.
- T0: PCout, MARin, IncPC, ZLowIn = 1. -> T1.
- T1: Read=1, MDRin=1 every cycle. Zlowout=1 and PCin=1 on the first T1 cycle only.
  - Stay in T1 while mem_ready=0.
  - mem_ready=1 -> T2.
- T2: MDRout=1, IRin=1. -> T3.
- T3: decode ir_in (IR loaded at end of T2).
  - Legal opcode: reg_out_sel = 1<<rb; Yin=1; -> T4.
  - Illegal opcode: no strobes; -> TRAP.
- T4: reg_out_sel = 1<<rc; alu_op = opcode; ZLowIn=1. -> T5.
  - alu_op holds its value until the next T4 or Reset, so the ALU result stays stable.
- T5: Zlowout=1; reg_in_sel = 1<<ra; done=1.
  - run=1 -> T0; otherwise -> IDLE.
- TRAP: illegal=1 for one cycle -> IDLE. Registers are not written.
- Same-register sources (rb==rc) and destination equal to a source are legal; the sequence is unchanged.
- start is ignored while busy=1.
- Fetch-to-writeback latency: 6 cycles with mem_ready high, plus 1 cycle per wait state.
- reg_out_sel and reg_in_sel are never both nonzero in one cycle. At most one bus driver (PCout, Zlowout, MDRout, reg_out_sel) is active per cycle.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A wait counter increments each T1 cycle with mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES: mem_err pulses 1 cycle, Read and MDRin drop, state -> IDLE, IR is not loaded.
  - The counter clears on T1 exit.
- Not defined: T1 waits indefinitely; mem_err is tied to 0 and no counter exists.

Test Plan:
- OR r1,r2,r3 (ir_in=0x18918000, mem_ready=1, start pulse) -> T0..T5 in 6 cycles. T3 reg_out_sel=0x0004 with Yin. T4 reg_out_sel=0x0008, alu_op=3. T5 reg_in_sel=0x0002, done=1. Then IDLE.
- Same instruction with mem_ready low 3 cycles in T1 -> T1 lasts 4 cycles. PCin high only in the first. Read/MDRin high all 4. Total 9 cycles.
- ir_in=0xF8000000 (opcode 31) -> after T3 comes TRAP. illegal=1 one cycle. reg_in_sel stays 0. busy drops next cycle.
- run=1 held, two back-to-back instructions -> T5 is followed directly by T0. done pulses every 6 cycles. busy never drops.
- Reset asserted mid-T4 -> all outputs 0 immediately without a clock edge. After release, start is required to resume.
- With MEM_TIMEOUT_EN and mem_ready=0 -> after 15 T1 cycles, mem_err pulses and state returns to IDLE. Without the macro -> FSM stays in T1 for 100+ cycles and mem_err stays 0.
